uart_rcvr: RTL and testbench
============================

// Module: uart_rcvr
// PURPOSE
//  Serial receiver paired with UART_XMTR; consumes its Serial_out line.
//  Detects the start bit and samples WORD_SIZE data bits LSB-first at mid-bit, then samples the stop bit.
//  Presents the word on a parallel register with a ready/acknowledge handshake to the host.
//  Flags overrun (Error1) and framing (Error2) errors.
// PARAMETERS
//  WORD_SIZE     8  data bits per frame (frame = 1 start + WORD_SIZE data + 1 stop)
//  CLKS_PER_BIT  1  Clock cycles per serial bit; 1 matches UART_XMTR (one bit per Clock); >=1
//  HALF_BIT      (CLKS_PER_BIT-1)/2  derived localparam, start-bit mid-point offset
// PORTS
//  Clock              in   1          rising-edge system clock
//  rst                in   1          asynchronous, active-high reset
//  Serial_in          in   1          serial line; idle high; board/bench holds it high when not driven
//  read_not_ready_in  in   1          host acknowledge: word read, clear ready/error flags
//  RCV_datareg        out  WORD_SIZE  last received word
//  read_not_ready_out out  1          1 = unread word valid in RCV_datareg
//  Error1             out  1          overrun: word completed while the previous one was unread
//  Error2             out  1          framing: stop bit sampled 0
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): state IDLE; counters 0; shift reg 0; RCV_datareg=0;
//    read_not_ready_out=0; Error1=0; Error2=0; partial frame discarded.
//  States: IDLE, START, DATA, STOP. sample_cnt counts 0..CLKS_PER_BIT-1; bit_cnt counts 0..WORD_SIZE.
//  IDLE: Serial_in==0 -> DATA if HALF_BIT==0, else START; sample_cnt=0.
//  START: sample_cnt++ each Clock; Serial_in==1 before confirm -> IDLE (glitch, no flags);
//    sample_cnt==HALF_BIT-1 and Serial_in==0 -> DATA, sample_cnt=0, bit_cnt=0.
//  DATA: sample_cnt wraps at CLKS_PER_BIT-1; on wrap sample Serial_in into shift-reg MSB, shift right.
//    bit_cnt++; bit_cnt reaching WORD_SIZE -> STOP.
//  STOP: on sample_cnt wrap sample stop bit.
//    shift reg -> RCV_datareg; read_not_ready_out=1; -> IDLE.
//    Error2 set if stop bit==0; the word is still delivered.
//    Error1 set if read_not_ready_out was already 1 and not acknowledged in the same cycle; old word is overwritten.
//  Latency: read_not_ready_out rises on Clock edge 1+HALF_BIT+(WORD_SIZE+1)*CLKS_PER_BIT after the start-bit fall.
//    CLKS_PER_BIT=1: edge 10. CLKS_PER_BIT=8: edge 76.
//  Handshake: read_not_ready_in==1 while read_not_ready_out==1 clears read_not_ready_out, Error1 and Error2 next edge.
//    Ack with nothing ready has no effect. RCV_datareg holds its value until the next frame.
//  Simultaneous ack and frame completion: new word wins; read_not_ready_out stays 1; Error1 not set; Error2 follows the new frame.
//  Error flags are sticky until ack or reset.
//  Back-to-back frames: IDLE accepts a new start bit on the cycle right after the STOP sample; no dead cycles.
//  Line low in IDLE after a framing error (break) starts a new frame; the frame is not suppressed.
// STRUCTURE
//  Package uart_pkg: state encoding (IDLE/START/DATA/STOP), WORD_SIZE default, idle/start/stop bit level constants.
//    UART_XMTR rewrites share the package.
//  Sub-module uart_rcvr_bit_timer: sample_cnt with wrap pulse and HALF_BIT confirm pulse.
//  Top holds the FSM, shift reg, bit_cnt, output regs.
//  All flops async-reset on rst; no latches; single Clock domain.
// TESTING
//  CLKS_PER_BIT=1, driven by UART_XMTR, Data_Bus=8'hA5 -> RCV_datareg=8'hA5, read_not_ready_out=1 at edge 10, Error1=Error2=0.
//  Two frames 8'h3C then 8'hC3, ack between them -> both received in order; no errors; no gap needed.
//  Two frames 8'h01, 8'hFF, no ack -> RCV_datareg=8'hFF, Error1=1; ack -> read_not_ready_out=Error1=0.
//  Direct drive, stop bit 0, data 8'h55 -> RCV_datareg=8'h55, Error2=1, read_not_ready_out=1.
//  CLKS_PER_BIT=8: 2-cycle low glitch -> stays IDLE, no flags; frame 8'h96 -> ready at edge 76, data 8'h96.
//  rst pulsed after data bit 4 of 8'hF0 -> all outputs 0 at once; next frame 8'h0F received clean.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and line-level constants shared by the UART receiver and transmitter
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
    localparam int WORD_SIZE_DEF = 8;
    localparam logic IDLE_BIT = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/uart_rcvr_if.sv
// uart_rcvr_if: serial line plus host-side word/handshake signals of the UART receiver
interface uart_rcvr_if import uart_pkg::*; #(
    parameter int WORD_SIZE = WORD_SIZE_DEF
) ();
    logic Serial_in;
    logic read_not_ready_in;
    logic [WORD_SIZE-1:0] RCV_datareg;
    logic read_not_ready_out;
    logic Error1;
    logic Error2;
    modport slave (
        input Serial_in, read_not_ready_in,
        output RCV_datareg, read_not_ready_out, Error1, Error2
    );
    modport master (
        output Serial_in, read_not_ready_in,
        input RCV_datareg, read_not_ready_out, Error1, Error2
    );
endinterface

// File: rtl/uart_rcvr_bit_timer.sv
// uart_rcvr_bit_timer: per-bit sample counter with bit-end wrap and start-bit mid-point confirm pulses
module uart_rcvr_bit_timer import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 1,
    parameter int HALF_BIT = 0
) (
    input  logic Clock,
    input  logic rst,
    input  logic clear,
    output logic wrap,
    output logic confirm
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT > 0 ? HALF_BIT - 1 : 0);
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    assign wrap = sample_cnt_q == LAST;
    assign confirm = sample_cnt_q == HALF_LAST;
    // restart on clear, otherwise count and roll over at the end of each bit
    always_comb sample_cnt_d = (clear || wrap) ? '0 : sample_cnt_q + 1'b1;
    // sample counter register
    always_ff @(posedge Clock or posedge rst)
        if (rst) sample_cnt_q <= '0;
        else sample_cnt_q <= sample_cnt_d;
endmodule

// File: rtl/uart_rcvr.sv
// uart_rcvr: start-bit detect, mid-bit LSB-first sampling, stop check and ready/ack host handshake
module uart_rcvr import uart_pkg::*; #(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int CLKS_PER_BIT = 1
) (
    input logic Clock,
    input logic rst,
    uart_rcvr_if.slave u
);
    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int BW = $clog2(WORD_SIZE + 1);
    uart_state_e state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [WORD_SIZE-1:0] shift_q, shift_d, data_q, data_d;
    logic ready_q, ready_d, err1_q, err1_d, err2_q, err2_d;
    logic clear, wrap, confirm, ack;
    uart_rcvr_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .HALF_BIT(HALF_BIT)) timer (
        .Clock(Clock), .rst(rst), .clear(clear), .wrap(wrap), .confirm(confirm)
    );
    assign ack = u.read_not_ready_in && ready_q;
    assign u.RCV_datareg = data_q;
    assign u.read_not_ready_out = ready_q;
    assign u.Error1 = err1_q;
    assign u.Error2 = err2_q;
    // frame FSM; a completing frame overrides a same-cycle ack so the new word stays flagged ready
    always_comb begin
        state_d = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d = shift_q;
        data_d = data_q;
        ready_d = ack ? 1'b0 : ready_q;
        err1_d = ack ? 1'b0 : err1_q;
        err2_d = ack ? 1'b0 : err2_q;
        clear = 1'b0;
        case (state_q)
            IDLE: begin
                clear = 1'b1;
                bit_cnt_d = '0;
                if (u.Serial_in == START_BIT) state_d = HALF_BIT == 0 ? DATA : START;
            end
            START: begin
                if (u.Serial_in != START_BIT) begin
                    state_d = IDLE;
                    clear = 1'b1;
                end else if (confirm) begin
                    state_d = DATA;
                    clear = 1'b1;
                end
            end
            DATA: begin
                if (wrap) begin
                    shift_d = {u.Serial_in, shift_q[WORD_SIZE-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == BW'(WORD_SIZE)) state_d = STOP;
                end
            end
            STOP: begin
                if (wrap) begin
                    data_d = shift_q;
                    ready_d = 1'b1;
                    err1_d = !ack && (err1_q || ready_q);
                    err2_d = (!ack && err2_q) || (u.Serial_in != STOP_BIT);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state, datapath and host-visible output registers
    always_ff @(posedge Clock or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            bit_cnt_q <= '0;
            shift_q <= '0;
            data_q <= '0;
            ready_q <= 1'b0;
            err1_q <= 1'b0;
            err2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q <= shift_d;
            data_q <= data_d;
            ready_q <= ready_d;
            err1_q <= err1_d;
            err2_q <= err2_d;
        end
endmodule

// File: tb/tb_uart_rcvr.sv
// tb_uart_rcvr: directed frames into one-clock-per-bit and eight-clocks-per-bit receivers
module tb_uart_rcvr;
    logic Clock = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;
    logic pre_ready;
    logic [7:0] pat;
    uart_rcvr_if #(.WORD_SIZE(8)) i1 ();
    uart_rcvr_if #(.WORD_SIZE(8)) i8 ();
    uart_rcvr #(.WORD_SIZE(8), .CLKS_PER_BIT(1)) d1 (.Clock(Clock), .rst(rst), .u(i1));
    uart_rcvr #(.WORD_SIZE(8), .CLKS_PER_BIT(8)) d8 (.Clock(Clock), .rst(rst), .u(i8));
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input int cpb, input logic b);
        if (cpb == 1) i1.Serial_in = b;
        else i8.Serial_in = b;
    endtask

    task automatic ack1();
        i1.read_not_ready_in = 1'b1;
        @(negedge Clock);
        i1.read_not_ready_in = 1'b0;
    endtask

    task automatic frame(input int cpb, input logic [7:0] d, input logic stop, input logic ack_last);
        line(cpb, 1'b0);
        repeat (cpb) @(negedge Clock);
        for (int i = 0; i < 8; i++) begin
            line(cpb, d[i]);
            repeat (cpb) @(negedge Clock);
        end
        line(cpb, stop);
        repeat ((cpb - 1) / 2) @(negedge Clock);
        pre_ready = cpb == 1 ? i1.read_not_ready_out : i8.read_not_ready_out;
        if (ack_last) i1.read_not_ready_in = 1'b1;
        @(negedge Clock);
        if (ack_last) i1.read_not_ready_in = 1'b0;
        line(cpb, 1'b1);
    endtask

    initial begin
        i1.Serial_in = 1'b1;
        i8.Serial_in = 1'b1;
        i1.read_not_ready_in = 1'b0;
        i8.read_not_ready_in = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rst_data", i1.RCV_datareg, 8'h00);
        chk("rst_ready", i1.read_not_ready_out, 1'b0);
        chk("rst_err1", i1.Error1, 1'b0);
        chk("rst_err2", i1.Error2, 1'b0);
        chk("rst8_data", i8.RCV_datareg, 8'h00);
        chk("rst8_ready", i8.read_not_ready_out, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge Clock);

        frame(1, 8'hA5, 1'b1, 1'b0);
        chk("a5_edge9_ready", pre_ready, 1'b0);
        chk("a5_edge10_ready", i1.read_not_ready_out, 1'b1);
        chk("a5_data", i1.RCV_datareg, 8'hA5);
        chk("a5_err1", i1.Error1, 1'b0);
        chk("a5_err2", i1.Error2, 1'b0);
        ack1();
        chk("a5_ack_ready", i1.read_not_ready_out, 1'b0);
        chk("a5_hold_data", i1.RCV_datareg, 8'hA5);

        frame(1, 8'h3C, 1'b1, 1'b0);
        chk("3c_data", i1.RCV_datareg, 8'h3C);
        i1.read_not_ready_in = 1'b1;
        frame(1, 8'hC3, 1'b1, 1'b0);
        i1.read_not_ready_in = 1'b0;
        chk("c3_data", i1.RCV_datareg, 8'hC3);
        chk("c3_ready", i1.read_not_ready_out, 1'b1);
        chk("c3_err1", i1.Error1, 1'b0);
        chk("c3_err2", i1.Error2, 1'b0);
        ack1();

        frame(1, 8'h01, 1'b1, 1'b0);
        frame(1, 8'hFF, 1'b1, 1'b0);
        chk("ovr_data", i1.RCV_datareg, 8'hFF);
        chk("ovr_err1", i1.Error1, 1'b1);
        chk("ovr_ready", i1.read_not_ready_out, 1'b1);
        chk("ovr_err2", i1.Error2, 1'b0);
        ack1();
        chk("ovr_ack_ready", i1.read_not_ready_out, 1'b0);
        chk("ovr_ack_err1", i1.Error1, 1'b0);

        frame(1, 8'h11, 1'b1, 1'b0);
        frame(1, 8'h22, 1'b1, 1'b1);
        chk("sim_data", i1.RCV_datareg, 8'h22);
        chk("sim_ready", i1.read_not_ready_out, 1'b1);
        chk("sim_err1", i1.Error1, 1'b0);
        ack1();

        frame(1, 8'h55, 1'b0, 1'b0);
        chk("frm_data", i1.RCV_datareg, 8'h55);
        chk("frm_err2", i1.Error2, 1'b1);
        chk("frm_ready", i1.read_not_ready_out, 1'b1);
        chk("frm_err1", i1.Error1, 1'b0);
        frame(1, 8'h5A, 1'b1, 1'b0);
        chk("brk_data", i1.RCV_datareg, 8'h5A);
        chk("brk_err1", i1.Error1, 1'b1);
        chk("brk_err2", i1.Error2, 1'b1);
        ack1();
        chk("brk_ack_ready", i1.read_not_ready_out, 1'b0);
        chk("brk_ack_err1", i1.Error1, 1'b0);
        chk("brk_ack_err2", i1.Error2, 1'b0);

        i8.Serial_in = 1'b0;
        repeat (2) @(negedge Clock);
        i8.Serial_in = 1'b1;
        repeat (90) @(negedge Clock);
        chk("glitch_ready", i8.read_not_ready_out, 1'b0);
        chk("glitch_err1", i8.Error1, 1'b0);
        chk("glitch_err2", i8.Error2, 1'b0);
        chk("glitch_data", i8.RCV_datareg, 8'h00);
        frame(8, 8'h96, 1'b1, 1'b0);
        chk("96_edge75_ready", pre_ready, 1'b0);
        chk("96_edge76_ready", i8.read_not_ready_out, 1'b1);
        chk("96_data", i8.RCV_datareg, 8'h96);
        chk("96_err2", i8.Error2, 1'b0);
        repeat (8) @(negedge Clock);

        pat = 8'hF0;
        i8.Serial_in = 1'b0;
        repeat (8) @(negedge Clock);
        for (int i = 0; i < 5; i++) begin
            i8.Serial_in = pat[i];
            repeat (8) @(negedge Clock);
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_data8", i8.RCV_datareg, 8'h00);
        chk("arst_ready8", i8.read_not_ready_out, 1'b0);
        chk("arst_data1", i1.RCV_datareg, 8'h00);
        @(negedge Clock);
        rst = 1'b0;
        i8.Serial_in = 1'b1;
        repeat (16) @(negedge Clock);
        frame(8, 8'h0F, 1'b1, 1'b0);
        chk("0f_data", i8.RCV_datareg, 8'h0F);
        chk("0f_ready", i8.read_not_ready_out, 1'b1);
        chk("0f_err1", i8.Error1, 1'b0);
        chk("0f_err2", i8.Error2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
